// File: rtl/cdb_broadcast.sv
// rtl/cdb_broadcast.sv - Common Data Bus stage with one holding register per FU class (optional tag check: CDB_TAG_CHECK_EN)
module cdb_broadcast #(
    parameter int NUM_FU      = 4,
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          select_flag,
    input  logic [$clog2(NUM_FU)-1:0]     select_signal,
    input  logic [NUM_FU-1:0]             fu_done,
    input  logic [NUM_FU*ROB_TAG_LEN-1:0] fu_rob_tag,
    input  logic [NUM_FU*XLEN-1:0]        fu_result,
`ifdef CDB_TAG_CHECK_EN
    input  logic [ROB_TAG_LEN-1:0]        issue_rob_tag,
    output logic                          err_tag,
`endif
    output logic                          cdb_valid,
    output logic [ROB_TAG_LEN-1:0]        cdb_tag,
    output logic [XLEN-1:0]               cdb_value,
    output logic [$clog2(NUM_FU)-1:0]     cdb_fu,
    output logic [NUM_FU-1:0]             hold_full,
    output logic                          err_underflow,
    output logic [NUM_FU-1:0]             err_overflow
);

    localparam int FU_W = $clog2(NUM_FU);
    localparam logic [FU_W-1:0] FU_LSU = '0;

    logic [NUM_FU-1:0]      hold_valid_q, hold_valid_d;
    logic [ROB_TAG_LEN-1:0] hold_tag_q   [NUM_FU];
    logic [ROB_TAG_LEN-1:0] hold_tag_d   [NUM_FU];
    logic [XLEN-1:0]        hold_value_q [NUM_FU];
    logic [XLEN-1:0]        hold_value_d [NUM_FU];
    logic [ROB_TAG_LEN-1:0] live_tag     [NUM_FU];
    logic [XLEN-1:0]        live_value   [NUM_FU];

    logic                   cdb_valid_q, cdb_valid_d;
    logic [ROB_TAG_LEN-1:0] cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]        cdb_value_q, cdb_value_d;
    logic [FU_W-1:0]        cdb_fu_q, cdb_fu_d;
    logic                   err_underflow_q, err_underflow_d;
    logic [NUM_FU-1:0]      err_overflow_q, err_overflow_d;
`ifdef CDB_TAG_CHECK_EN
    logic                   err_tag_q, err_tag_d;
`endif

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            live_tag[i]   = fu_rob_tag[i*ROB_TAG_LEN +: ROB_TAG_LEN];
            live_value[i] = fu_result[i*XLEN +: XLEN];
        end
    end

    always_comb begin
        hold_valid_d    = hold_valid_q;
        hold_tag_d      = hold_tag_q;
        hold_value_d    = hold_value_q;
        cdb_valid_d     = 1'b0;
        cdb_tag_d       = cdb_tag_q;
        cdb_value_d     = cdb_value_q;
        cdb_fu_d        = cdb_fu_q;
        err_underflow_d = err_underflow_q;
        err_overflow_d  = err_overflow_q;

        if (flush) begin
            hold_valid_d = '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (select_flag && (select_signal == FU_W'(i))) begin
                    // The hold is always older than the live result, so it goes first.
                    if (hold_valid_q[i]) begin
                        cdb_valid_d     = 1'b1;
                        cdb_tag_d       = hold_tag_q[i];
                        cdb_value_d     = hold_value_q[i];
                        cdb_fu_d        = FU_W'(i);
                        hold_valid_d[i] = fu_done[i];
                        if (fu_done[i]) begin
                            hold_tag_d[i]   = live_tag[i];
                            hold_value_d[i] = live_value[i];
                        end
                    end else if (fu_done[i]) begin
                        cdb_valid_d = 1'b1;
                        cdb_tag_d   = live_tag[i];
                        cdb_value_d = live_value[i];
                        cdb_fu_d    = FU_W'(i);
                    end else begin
                        err_underflow_d = 1'b1;
                    end
                end else if (fu_done[i]) begin
                    if (!hold_valid_q[i]) begin
                        hold_valid_d[i] = 1'b1;
                        hold_tag_d[i]   = live_tag[i];
                        hold_value_d[i] = live_value[i];
                    end else begin
                        err_overflow_d[i] = 1'b1;
                    end
                end
            end
        end
    end

`ifdef CDB_TAG_CHECK_EN
    always_comb begin
        err_tag_d = err_tag_q;
        if (cdb_valid_d && (cdb_tag_d != issue_rob_tag)) begin
            err_tag_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid_q    <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                hold_tag_q[i]   <= '0;
                hold_value_q[i] <= '0;
            end
            cdb_valid_q     <= 1'b0;
            cdb_tag_q       <= '0;
            cdb_value_q     <= '0;
            cdb_fu_q        <= FU_LSU;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= '0;
`ifdef CDB_TAG_CHECK_EN
            err_tag_q       <= 1'b0;
`endif
        end else begin
            hold_valid_q    <= hold_valid_d;
            hold_tag_q      <= hold_tag_d;
            hold_value_q    <= hold_value_d;
            cdb_valid_q     <= cdb_valid_d;
            cdb_tag_q       <= cdb_tag_d;
            cdb_value_q     <= cdb_value_d;
            cdb_fu_q        <= cdb_fu_d;
            err_underflow_q <= err_underflow_d;
            err_overflow_q  <= err_overflow_d;
`ifdef CDB_TAG_CHECK_EN
            err_tag_q       <= err_tag_d;
`endif
        end
    end

    assign cdb_valid     = cdb_valid_q;
    assign cdb_tag       = cdb_tag_q;
    assign cdb_value     = cdb_value_q;
    assign cdb_fu        = cdb_fu_q;
    assign hold_full     = hold_valid_q;
    assign err_underflow = err_underflow_q;
    assign err_overflow  = err_overflow_q;
`ifdef CDB_TAG_CHECK_EN
    assign err_tag       = err_tag_q;
`endif

endmodule

// File: tb/tb_cdb_broadcast.sv
// tb/tb_cdb_broadcast.sv - directed self-checking bench for cdb_broadcast
module tb_cdb_broadcast;

    localparam int NUM_FU = 4;
    localparam int XLEN   = 32;
    localparam int TAGW   = 6;
    localparam int LSU = 0, MULT = 1, BTU = 2, ALU = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   flush;
    logic                   select_flag;
    logic [1:0]             select_signal;
    logic [NUM_FU-1:0]      fu_done;
    logic [NUM_FU*TAGW-1:0] fu_rob_tag;
    logic [NUM_FU*XLEN-1:0] fu_result;
    logic                   cdb_valid;
    logic [TAGW-1:0]        cdb_tag;
    logic [XLEN-1:0]        cdb_value;
    logic [1:0]             cdb_fu;
    logic [NUM_FU-1:0]      hold_full;
    logic                   err_underflow;
    logic [NUM_FU-1:0]      err_overflow;
`ifdef CDB_TAG_CHECK_EN
    logic [TAGW-1:0]        issue_rob_tag;
    logic                   err_tag;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    cdb_broadcast #(.NUM_FU(NUM_FU), .XLEN(XLEN), .ROB_TAG_LEN(TAGW)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .select_flag   (select_flag),
        .select_signal (select_signal),
        .fu_done       (fu_done),
        .fu_rob_tag    (fu_rob_tag),
        .fu_result     (fu_result),
`ifdef CDB_TAG_CHECK_EN
        .issue_rob_tag (issue_rob_tag),
        .err_tag       (err_tag),
`endif
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_value     (cdb_value),
        .cdb_fu        (cdb_fu),
        .hold_full     (hold_full),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush         = 1'b0;
        select_flag   = 1'b0;
        select_signal = 2'd0;
        fu_done       = '0;
        fu_rob_tag    = '0;
        fu_result     = '0;
`ifdef CDB_TAG_CHECK_EN
        issue_rob_tag = '0;
`endif
    endtask

    task automatic present(input int u, input logic [TAGW-1:0] tag, input logic [XLEN-1:0] val);
        fu_done[u]                 = 1'b1;
        fu_rob_tag[u*TAGW +: TAGW] = tag;
        fu_result[u*XLEN +: XLEN]  = val;
    endtask

    task automatic grant(input int u);
        select_flag   = 1'b1;
        select_signal = 2'(u);
    endtask

    // Advance one edge, then leave inputs idle for the caller to check and re-drive.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cdb_valid", cdb_valid, 0);
        check_eq("rst_cdb_tag", cdb_tag, 0);
        check_eq("rst_cdb_value", cdb_value, 0);
        check_eq("rst_cdb_fu", cdb_fu, LSU);
        check_eq("rst_hold_full", hold_full, 0);
        check_eq("rst_err_underflow", err_underflow, 0);
        check_eq("rst_err_overflow", err_overflow, 0);
        reset = 1'b1;

        // capture into ALU hold, then broadcast it
        present(ALU, 6'd5, 32'hDEAD);
        tick();
        check_eq("alu_hold_full", hold_full, 4'b1000);
        check_eq("alu_no_bcast", cdb_valid, 0);
        grant(ALU);
        tick();
        check_eq("alu_valid", cdb_valid, 1);
        check_eq("alu_tag", cdb_tag, 5);
        check_eq("alu_value", cdb_value, 32'hDEAD);
        check_eq("alu_fu", cdb_fu, ALU);
        check_eq("alu_hold_empty", hold_full, 0);
        tick();
        check_eq("pulse_valid", cdb_valid, 0);
        check_eq("pulse_tag_kept", cdb_tag, 5);
        check_eq("pulse_value_kept", cdb_value, 32'hDEAD);

        // bypass on MULT
        grant(MULT);
        present(MULT, 6'd7, 32'd42);
        tick();
        check_eq("byp_valid", cdb_valid, 1);
        check_eq("byp_tag", cdb_tag, 7);
        check_eq("byp_value", cdb_value, 42);
        check_eq("byp_fu", cdb_fu, MULT);
        check_eq("byp_hold", hold_full, 0);

        // held MULT result goes first, live one refills the hold
        present(MULT, 6'd3, 32'd33);
        tick();
        check_eq("mul_hold_set", hold_full, 4'b0010);
        grant(MULT);
        present(MULT, 6'd4, 32'd44);
        tick();
        check_eq("mul_old_valid", cdb_valid, 1);
        check_eq("mul_old_tag", cdb_tag, 3);
        check_eq("mul_old_value", cdb_value, 33);
        check_eq("mul_hold_kept", hold_full, 4'b0010);
        grant(MULT);
        tick();
        check_eq("mul_new_valid", cdb_valid, 1);
        check_eq("mul_new_tag", cdb_tag, 4);
        check_eq("mul_new_value", cdb_value, 44);
        check_eq("mul_hold_clear", hold_full, 0);

        // LSU overflow keeps the older result
        present(LSU, 6'd1, 32'd11);
        tick();
        present(LSU, 6'd2, 32'd22);
        tick();
        check_eq("ovf_err", err_overflow, 4'b0001);
        check_eq("ovf_hold", hold_full, 4'b0001);
        grant(LSU);
        tick();
        check_eq("ovf_bcast_valid", cdb_valid, 1);
        check_eq("ovf_bcast_tag", cdb_tag, 1);
        check_eq("ovf_bcast_value", cdb_value, 11);
        check_eq("ovf_bcast_fu", cdb_fu, LSU);

        // underflow on empty BTU
        grant(BTU);
        tick();
        check_eq("unf_valid", cdb_valid, 0);
        check_eq("unf_err", err_underflow, 1);
        check_eq("unf_tag_kept", cdb_tag, 1);

        // flush beats grant and capture
        present(LSU, 6'd10, 32'd100);
        present(MULT, 6'd11, 32'd101);
        present(BTU, 6'd12, 32'd102);
        present(ALU, 6'd13, 32'd103);
        tick();
        check_eq("fl_all_full", hold_full, 4'b1111);
        flush = 1'b1;
        grant(ALU);
        present(BTU, 6'd14, 32'd104);
        tick();
        check_eq("fl_hold_empty", hold_full, 0);
        check_eq("fl_no_bcast", cdb_valid, 0);
        check_eq("fl_unf_sticky", err_underflow, 1);
        check_eq("fl_ovf_sticky", err_overflow, 4'b0001);

`ifdef CDB_TAG_CHECK_EN
        present(ALU, 6'd8, 32'd88);
        tick();
        check_eq("tag_pre", err_tag, 0);
        grant(ALU);
        issue_rob_tag = 6'd9;
        tick();
        check_eq("tag_bcast", cdb_tag, 8);
        check_eq("tag_valid", cdb_valid, 1);
        check_eq("tag_err", err_tag, 1);
`endif

        // async reset in the middle of a broadcast, with a grant pending
        present(ALU, 6'd6, 32'h1234);
        tick();
        grant(ALU);
        tick();
        check_eq("mid_valid", cdb_valid, 1);
        check_eq("mid_tag", cdb_tag, 6);
        present(BTU, 6'd15, 32'd5);
        grant(BTU);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_valid", cdb_valid, 0);
        check_eq("arst_tag", cdb_tag, 0);
        check_eq("arst_value", cdb_value, 0);
        check_eq("arst_fu", cdb_fu, LSU);
        check_eq("arst_hold", hold_full, 0);
        check_eq("arst_unf", err_underflow, 0);
        check_eq("arst_ovf", err_overflow, 0);
`ifdef CDB_TAG_CHECK_EN
        check_eq("arst_tag_err", err_tag, 0);
`endif
        tick();
        check_eq("arst_no_complete", cdb_valid, 0);
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
